hex_score_display: RTL and testbench

- Sequential binary-to-decimal seven-segment display controller for the game score, level and line counters.
- Sits between a PIO-exported binary value and the board HEX digits.
- Generalises the fixed per-digit hex drivers to:
  - N decimal digits
  - signed or unsigned input
  - leading-zero blanking
  - overflow indication
  - blink mode
- Conversion is iterative: double-dabble, one input bit per cycle.

---
 rtl/hex_score_display.sv | 177 +++++++++++++++++
 tb/tb_hex_score_display.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hex_score_display.sv
// rtl/hex_score_display.sv - iterative binary-to-decimal seven-segment score display
// Double-dabble conversion, one input bit per cycle, with sign, blanking, overflow and blink.
module hex_score_display #(
   parameter int DIGITS    = 6,
   parameter int VAL_W     = 20,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  load,
   input  logic [VAL_W-1:0]      value,
   input  logic                  is_signed,
   input  logic                  blank_lz,
   input  logic                  blink_en,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [8*DIGITS-1:0]   seg
);

   localparam int NBCD = (VAL_W * 3) / 10 + 1;
   localparam int MAXD = (NBCD > DIGITS) ? NBCD : DIGITS;
   localparam int CW   = (VAL_W > 1) ? $clog2(VAL_W) : 1;
   localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [7:0] SEG_MINUS = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

   state_t                state, state_next;
   logic                  load_q, sgn_q, blz_q;
   logic [VAL_W-1:0]      val_q;
   logic [VAL_W-1:0]      mag;
   logic                  neg, blz;
   logic [4*NBCD-1:0]     bcd, bcd_adj;
   logic [4*MAXD-1:0]     bcd_ext;
   logic [CW-1:0]         bit_cnt;
   logic [8*DIGITS-1:0]   seg_r, seg_fmt;
   logic                  ovf_r, ovf_fmt, done_r;
   logic [BW-1:0]         blink_cnt;
   logic                  phase;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   always_ff @(posedge Clk) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load_q) state_next = SHIFT;
         SHIFT:   if (bit_cnt == '0) state_next = FORMAT;
         FORMAT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A captured-but-not-yet-started load already counts as busy so a second load is dropped.
   always_comb begin
      busy = (state != IDLE) | load_q;
   end

   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < NBCD; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
   end

   assign bcd_ext = (4*MAXD)'(bcd);

   always_comb begin
      int avail;
      int msd;
      avail   = neg ? DIGITS - 1 : DIGITS;
      msd     = 0;
      ovf_fmt = 1'b0;
      seg_fmt = '1;
      for (int d = 0; d < MAXD; d++) begin
         if (bcd_ext[4*d +: 4] != 4'd0) begin
            msd = d;
            if (d >= avail) ovf_fmt = 1'b1;
         end
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (ovf_fmt)
            seg_fmt[8*i +: 8] = SEG_MINUS;
         else if (blz) begin
            if (i <= msd)                   seg_fmt[8*i +: 8] = seg7(bcd_ext[4*i +: 4]);
            else if (neg && i == msd + 1)   seg_fmt[8*i +: 8] = SEG_MINUS;
            else                            seg_fmt[8*i +: 8] = SEG_BLANK;
         end else begin
            if (i < avail)                  seg_fmt[8*i +: 8] = seg7(bcd_ext[4*i +: 4]);
            else if (neg)                   seg_fmt[8*i +: 8] = SEG_MINUS;
            else                            seg_fmt[8*i +: 8] = SEG_BLANK;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         load_q  <= 1'b0;
         val_q   <= '0;
         sgn_q   <= 1'b0;
         blz_q   <= 1'b0;
         mag     <= '0;
         neg     <= 1'b0;
         blz     <= 1'b0;
         bcd     <= '0;
         bit_cnt <= '0;
         seg_r   <= '1;
         ovf_r   <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         load_q <= load & ~busy;
         val_q  <= value;
         sgn_q  <= is_signed;
         blz_q  <= blank_lz;
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (load_q) begin
                  neg     <= sgn_q & val_q[VAL_W-1];
                  mag     <= (sgn_q & val_q[VAL_W-1]) ? -val_q : val_q;
                  blz     <= blz_q;
                  bcd     <= '0;
                  bit_cnt <= CW'(VAL_W - 1);
               end
            end
            SHIFT: begin
               {bcd, mag} <= {bcd_adj[4*NBCD-2:0], mag, 1'b0};
               bit_cnt    <= bit_cnt - 1'b1;
            end
            FORMAT: begin
               seg_r  <= seg_fmt;
               ovf_r  <= ovf_fmt;
               done_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign done     = done_r;
   assign overflow = ovf_r;
   assign seg      = (blink_en & phase) ? '1 : seg_r;

endmodule

// File: tb/tb_hex_score_display.sv
// tb/tb_hex_score_display.sv - scoreboard bench for hex_score_display
module tb_hex_score_display;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        load = 1'b0;
   logic [19:0] value = '0;
   logic        is_signed = 1'b0;
   logic        blank_lz = 1'b0;
   logic        blink_en = 1'b0;
   logic        busy, done, overflow;
   logic [47:0] seg;

   int          total = 0;
   int          passed = 0;
   int          ecnt = 0;
   logic [48:0] exp_q[$];

   localparam logic [47:0] P1234 = 48'hFFFF_F9A4_B099;

   always #5 Clk = ~Clk;

   hex_score_display #(.DIGITS(6), .VAL_W(20), .BLINK_DIV(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .load(load), .value(value),
      .is_signed(is_signed), .blank_lz(blank_lz), .blink_en(blink_en),
      .busy(busy), .done(done), .overflow(overflow), .seg(seg)
   );

   // Edges since reset release, used to predict the blink phase.
   always @(posedge Clk) begin
      if (!Reset_n) ecnt <= 0;
      else          ecnt <= ecnt + 1;
   end

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   initial begin : monitor
      logic [48:0] e;
      forever begin
         @(negedge Clk);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_done", 48'(done), 48'd0);
            else begin
               e = exp_q.pop_front();
               check("seg", seg, e[48:1]);
               check("overflow", 48'(overflow), 48'(e[0]));
               check("busy_at_done", 48'(busy), 48'd0);
            end
         end
      end
   end

   task automatic conv(input logic [19:0] v, input logic s, input logic b,
                       input logic [47:0] es, input logic eo, input int intr);
      int n;
      exp_q.push_back({es, eo});
      @(negedge Clk);
      load = 1'b1; value = v; is_signed = s; blank_lz = b;
      @(negedge Clk);
      load = 1'b0; n = 0;
      check("busy_after_load", 48'(busy), 48'd1);
      while (done !== 1'b1 && n < 40) begin
         @(negedge Clk);
         n++;
         load = 1'b0;
         if (n == intr) begin
            load = 1'b1; value = 20'd7; is_signed = ~s; blank_lz = ~b;
         end
      end
      load = 1'b0;
      check("latency", 48'(n), 48'd22);
   endtask

   initial begin
      int n, dones;
      logic [47:0] e;
      repeat (3) @(negedge Clk);
      check("rst_seg", seg, 48'hFFFF_FFFF_FFFF);
      check("rst_busy", 48'(busy), 48'd0);
      check("rst_done", 48'(done), 48'd0);
      check("rst_ovf", 48'(overflow), 48'd0);
      Reset_n = 1'b1;

      conv(20'd1234,    1'b0, 1'b1, P1234,               1'b0, -1);
      conv(20'd1234,    1'b0, 1'b0, 48'hC0C0_F9A4_B099,  1'b0, -1);
      conv(20'hFFFD6,   1'b1, 1'b1, 48'hFFFF_FFBF_99A4,  1'b0, -1);
      conv(20'd0,       1'b0, 1'b1, 48'hFFFF_FFFF_FFC0,  1'b0, -1);
      conv(20'd1000000, 1'b0, 1'b1, 48'hBFBF_BFBF_BFBF,  1'b1, -1);
      conv(20'hE7960,   1'b1, 1'b1, 48'hBFBF_BFBF_BFBF,  1'b1, -1);
      conv(20'hE7961,   1'b1, 1'b0, 48'hBF90_9090_9090,  1'b0, -1);
      conv(20'h80000,   1'b1, 1'b1, 48'hBFBF_BFBF_BFBF,  1'b1, -1);
      conv(20'd999999,  1'b0, 1'b1, 48'h9090_9090_9090,  1'b0, -1);
      conv(20'hFFFFB,   1'b1, 1'b0, 48'hBFC0_C0C0_C092,  1'b0, -1);
      conv(20'hFFFD6,   1'b0, 1'b1, 48'hBFBF_BFBF_BFBF,  1'b1, -1);
      conv(20'd1234,    1'b0, 1'b1, P1234,               1'b0, 5);

      // Reset during conversion: no done, display blanked.
      @(negedge Clk);
      load = 1'b1; value = 20'd1234; is_signed = 1'b0; blank_lz = 1'b1;
      @(negedge Clk);
      load = 1'b0;
      repeat (10) @(negedge Clk);
      Reset_n = 1'b0;
      @(negedge Clk);
      check("midrst_seg", seg, 48'hFFFF_FFFF_FFFF);
      check("midrst_busy", 48'(busy), 48'd0);
      check("midrst_ovf", 48'(overflow), 48'd0);
      Reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clk);
         if (done === 1'b1) dones++;
      end
      check("midrst_no_done", 48'(dones), 48'd0);

      conv(20'd1234, 1'b0, 1'b1, P1234, 1'b0, -1);
      blink_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge Clk);
         e = (((ecnt / 4) % 2) == 1) ? 48'hFFFF_FFFF_FFFF : P1234;
         check("blink_on", seg, e);
      end
      blink_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         check("blink_off", seg, P1234);
      end

      repeat (2) @(negedge Clk);
      check("queue_drained", 48'(exp_q.size()), 48'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
